// File: rtl/cpu_pkg.sv
// Shared definitions for the EX/MEM pipeline register: FSM encoding,
// default memory latency and wait-counter width.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MEM_WAIT_DEFAULT = 2;
   localparam int CNT_W            = 3;

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter that times the stall cycles of a load/store.
// It saturates at zero; zero is a flag decoded from the count register.
module mem_wait_ctr
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a fixed-latency memory wait FSM. Loads and
// stores hold the stage for MEM_WAIT+1 cycles and freeze the front end.
module ex_mem_pipe
   import cpu_pkg::*;
#(
   parameter int MEM_WAIT = MEM_WAIT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] aluResult_ex,
   input  logic [31:0] writeData_ex,
   input  logic [4:0]  writeReg_ex,
   input  logic        zero_ex,
   input  logic        overflow_ex,
   input  logic        carryOut_ex,
   input  logic        negative_ex,
   input  logic        MemWrite_ex,
   input  logic        MemRead_ex,
   input  logic        Branch_ex,
   input  logic        RegWrite_ex,
   input  logic        MemtoReg_ex,
   input  logic        valid_ex,
   input  logic        flush,
   output logic [31:0] aluResult_mem,
   output logic [31:0] writeDataToSRAM,
   output logic [4:0]  writeReg_mem,
   output logic        zero_mem,
   output logic        overflow_mem,
   output logic        carryOut_mem,
   output logic        negative_mem,
   output logic        MemWrite_mem,
   output logic        MemRead_mem,
   output logic        Branch_mem,
   output logic        RegWrite_mem,
   output logic        MemtoReg_mem,
   output logic        valid_mem,
   output logic        stall_mem,
   output logic        memDone_mem
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = (MEM_WAIT > 0) ? CNT_W'(MEM_WAIT - 1) : '0;

   state_t      state_q, state_d;
   logic        flush_pending_q, flush_pending_d;
   logic [31:0] alu_q, alu_d, wdata_q, wdata_d;
   logic [4:0]  wreg_q, wreg_d;
   logic [3:0]  flags_q, flags_d;
   logic        mem_write_q, mem_write_d, mem_read_q, mem_read_d;
   logic        branch_q, branch_d, reg_write_q, reg_write_d;
   logic        mem_to_reg_q, mem_to_reg_d, valid_q, valid_d;

   logic capture, bubble, mem_op, cnt_load, cnt_zero;

   assign capture  = (state_q == IDLE) || (state_q == DONE);
   assign bubble   = !valid_ex || flush || flush_pending_q;
   assign mem_op   = MemRead_ex || MemWrite_ex;
   assign cnt_load = capture && !bubble && mem_op && (MEM_WAIT > 0);

   mem_wait_ctr u_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (state_q == WAIT),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d         = state_q;
      flush_pending_d = flush_pending_q;
      alu_d           = alu_q;
      wdata_d         = wdata_q;
      wreg_d          = wreg_q;
      flags_d         = flags_q;
      mem_write_d     = mem_write_q;
      mem_read_d      = mem_read_q;
      branch_d        = branch_q;
      reg_write_d     = reg_write_q;
      mem_to_reg_d    = mem_to_reg_q;
      valid_d         = valid_q;
      case (state_q)
         IDLE, DONE: begin
            alu_d           = aluResult_ex;
            wdata_d         = writeData_ex;
            wreg_d          = writeReg_ex;
            flags_d         = {zero_ex, overflow_ex, carryOut_ex, negative_ex};
            valid_d         = !bubble;
            mem_write_d     = MemWrite_ex  && !bubble;
            mem_read_d      = MemRead_ex   && !bubble;
            branch_d        = Branch_ex    && !bubble;
            reg_write_d     = RegWrite_ex  && !bubble;
            mem_to_reg_d    = MemtoReg_ex  && !bubble;
            flush_pending_d = 1'b0;
            if (!bubble && mem_op) begin
               state_d = (MEM_WAIT > 0) ? WAIT : DONE;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            // The write strobe lives only in the first cycle of the op.
            mem_write_d = 1'b0;
            if (flush) begin
               flush_pending_d = 1'b1;
            end
            if (cnt_zero) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         flush_pending_q <= 1'b0;
         alu_q           <= '0;
         wdata_q         <= '0;
         wreg_q          <= '0;
         flags_q         <= '0;
         mem_write_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         branch_q        <= 1'b0;
         reg_write_q     <= 1'b0;
         mem_to_reg_q    <= 1'b0;
         valid_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         flush_pending_q <= flush_pending_d;
         alu_q           <= alu_d;
         wdata_q         <= wdata_d;
         wreg_q          <= wreg_d;
         flags_q         <= flags_d;
         mem_write_q     <= mem_write_d;
         mem_read_q      <= mem_read_d;
         branch_q        <= branch_d;
         reg_write_q     <= reg_write_d;
         mem_to_reg_q    <= mem_to_reg_d;
         valid_q         <= valid_d;
      end
   end

   assign aluResult_mem   = alu_q;
   assign writeDataToSRAM = wdata_q;
   assign writeReg_mem    = wreg_q;
   assign zero_mem        = flags_q[3];
   assign overflow_mem    = flags_q[2];
   assign carryOut_mem    = flags_q[1];
   assign negative_mem    = flags_q[0];
   assign MemWrite_mem    = mem_write_q;
   assign MemRead_mem     = mem_read_q;
   assign Branch_mem      = branch_q;
   assign RegWrite_mem    = reg_write_q;
   assign MemtoReg_mem    = mem_to_reg_q;
   assign valid_mem       = valid_q;
   assign stall_mem       = (state_q == WAIT);
   assign memDone_mem     = (state_q == DONE);

endmodule
